// File: rtl/jesd204b_cgs_detector.sv
// Per-lane JESD204B code group synchronisation detector.
// Scans each accepted word octet by octet (octet 0 first in time) and runs the
// CS_INIT / CS_CHECK / CS_DATA lane sync FSM. It also keeps a saturating count
// of sync losses (CS_CHECK -> CS_INIT transitions) for debug.
module jesd204b_cgs_detector #(
  parameter int unsigned PARALLEL_OCTETS = 4,
  parameter int unsigned K_REQUIRED      = 4,
  parameter int unsigned INVALID_LIMIT   = 3,
  parameter int unsigned GOOD_REQUIRED   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cgs_rst_i,
  input  logic                         valid_i,
  input  logic [8*PARALLEL_OCTETS-1:0] data_i,
  input  logic [PARALLEL_OCTETS-1:0]   charisk_i,
  input  logic [PARALLEL_OCTETS-1:0]   notintable_i,
  input  logic [PARALLEL_OCTETS-1:0]   disperr_i,
  output logic                         cgs_detected_o,
  output logic [1:0]                   state_o,
  output logic [7:0]                   loss_cnt_o
);

  // Counters only need to reach their limit; they are cleared on reaching it.
  localparam int unsigned KW = $clog2(K_REQUIRED + 1);
  localparam int unsigned IW = $clog2(INVALID_LIMIT + 1);
  localparam int unsigned GW = $clog2(GOOD_REQUIRED + 1);

  typedef enum logic [1:0] {
    CsInit  = 2'd0,
    CsCheck = 2'd1,
    CsData  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_cnt_q, k_cnt_d;
  logic [IW-1:0] inv_cnt_q, inv_cnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [7:0]    loss_q, loss_d;

  logic [PARALLEL_OCTETS-1:0] octet_inv;
  logic [PARALLEL_OCTETS-1:0] octet_k;

  // Per-octet classification; a /K/ with a code error is not a /K/.
  always_comb begin
    octet_inv = '0;
    octet_k   = '0;
    for (int unsigned i = 0; i < PARALLEL_OCTETS; i++) begin
      octet_inv[i] = notintable_i[i] | disperr_i[i];
      octet_k[i]   = charisk_i[i] && (data_i[8*i +: 8] == 8'hBC) && !octet_inv[i];
    end
  end

  // Next state: walk the word octet by octet so a transition caused by octet i
  // already governs octet i+1 within the same cycle.
  always_comb begin
    state_d    = state_q;
    k_cnt_d    = k_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    good_cnt_d = good_cnt_q;
    loss_d     = loss_q;
    if (cgs_rst_i) begin
      // Resync request wins over any word presented alongside it.
      state_d    = CsInit;
      k_cnt_d    = '0;
      inv_cnt_d  = '0;
      good_cnt_d = '0;
    end else if (valid_i) begin
      for (int unsigned i = 0; i < PARALLEL_OCTETS; i++) begin
        unique case (state_d)
          CsInit: begin
            if (octet_k[i]) begin
              k_cnt_d = k_cnt_d + KW'(1);
              if (k_cnt_d == KW'(K_REQUIRED)) begin
                state_d = CsData;
                k_cnt_d = '0;
              end
            end else begin
              k_cnt_d = '0;
            end
          end
          CsData: begin
            if (octet_inv[i]) begin
              state_d    = CsCheck;
              inv_cnt_d  = IW'(1);
              good_cnt_d = '0;
            end
          end
          CsCheck: begin
            if (octet_inv[i]) begin
              inv_cnt_d  = inv_cnt_d + IW'(1);
              good_cnt_d = '0;
              if (inv_cnt_d == IW'(INVALID_LIMIT)) begin
                state_d    = CsInit;
                k_cnt_d    = '0;
                inv_cnt_d  = '0;
                good_cnt_d = '0;
                if (loss_d != 8'hFF) begin
                  loss_d = loss_d + 8'd1;
                end
              end
            end else begin
              good_cnt_d = good_cnt_d + GW'(1);
              if (good_cnt_d == GW'(GOOD_REQUIRED)) begin
                state_d    = CsData;
                inv_cnt_d  = '0;
                good_cnt_d = '0;
              end
            end
          end
          default: begin
            // Unreachable encoding: recover to a clean search.
            state_d    = CsInit;
            k_cnt_d    = '0;
            inv_cnt_d  = '0;
            good_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CsInit;
      k_cnt_q    <= '0;
      inv_cnt_q  <= '0;
      good_cnt_q <= '0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      inv_cnt_q  <= inv_cnt_d;
      good_cnt_q <= good_cnt_d;
      loss_q     <= loss_d;
    end
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    cgs_detected_o = (state_q == CsData) || (state_q == CsCheck);
    state_o        = state_q;
    loss_cnt_o     = loss_q;
  end

endmodule

// File: tb/tb_jesd204b_cgs_detector.sv
// Directed bench for jesd204b_cgs_detector: expected outputs are queued when a
// word is driven and popped/checked one clock later.
module tb_jesd204b_cgs_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cgs_rst;
  logic        valid;
  logic [31:0] data;
  logic [3:0]  charisk;
  logic [3:0]  notintable;
  logic [3:0]  disperr;
  logic        det;
  logic [1:0]  st;
  logic [7:0]  loss;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       det;
    logic [7:0] loss;
  } exp_t;

  exp_t  sb[$];
  string tag_q[$];

  localparam logic [31:0] KWORD = 32'hBCBC_BCBC;
  localparam logic [31:0] DWORD = 32'h1122_3344;

  always #5 clk = ~clk;

  jesd204b_cgs_detector dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cgs_rst_i      (cgs_rst),
    .valid_i        (valid),
    .data_i         (data),
    .charisk_i      (charisk),
    .notintable_i   (notintable),
    .disperr_i      (disperr),
    .cgs_detected_o (det),
    .state_o        (st),
    .loss_cnt_o     (loss)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      t = tag_q.pop_front();
      chk({t, "_state"}, {6'd0, st}, {6'd0, e.st});
      chk({t, "_det"}, {7'd0, det}, {7'd0, e.det});
      chk({t, "_loss"}, loss, e.loss);
    end
  endtask

  // Drive one word, queue its expected result, then check after the edge.
  task automatic step(input logic rs, input logic v, input logic [31:0] d,
                      input logic [3:0] k, input logic [3:0] nit, input logic [3:0] de,
                      input logic [1:0] est, input logic [7:0] eloss, input string tag);
    exp_t e;
    cgs_rst    = rs;
    valid      = v;
    data       = d;
    charisk    = k;
    notintable = nit;
    disperr    = de;
    e.st   = est;
    e.det  = (est != 2'd0);
    e.loss = eloss;
    sb.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    logic [7:0] l;
    rst_n      = 1'b0;
    cgs_rst    = 1'b0;
    valid      = 1'b0;
    data       = '0;
    charisk    = '0;
    notintable = '0;
    disperr    = '0;
    #12;
    chk("reset_state", {6'd0, st}, 8'd0);
    chk("reset_det", {7'd0, det}, 8'd0);
    chk("reset_loss", loss, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-/K/ word locks in one word.
    step(0, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd2, 8'd0, "t1_allk");
    step(1, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd0, 8'd0, "rst_to_init");
    // k_cnt clears on a non-/K/ octet; three /K/ are not enough.
    step(0, 1, 32'h00BC_BCBC, 4'h7, 4'h0, 4'h0, 2'd0, 8'd0, "t2_three_k");
    step(0, 1, 32'h00BC_BCBC, 4'h7, 4'h0, 4'h0, 2'd0, 8'd0, "t2_three_k_again");
    step(0, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd2, 8'd0, "t2_allk");
    // One invalid octet enters CS_CHECK; four good octets return to CS_DATA.
    step(0, 1, DWORD, 4'h0, 4'h1, 4'h0, 2'd1, 8'd0, "t3_check");
    step(0, 1, DWORD, 4'h0, 4'h0, 4'h0, 2'd2, 8'd0, "t3_back_data");
    // valid_i=0 holds CS_CHECK counters even with a garbage word.
    step(0, 1, DWORD, 4'h0, 4'h1, 4'h0, 2'd1, 8'd0, "hold_enter_check");
    step(0, 0, DWORD, 4'h0, 4'hF, 4'hF, 2'd1, 8'd0, "hold_check");
    step(0, 1, DWORD, 4'h0, 4'h0, 4'h0, 2'd2, 8'd0, "hold_resume");
    // inv_cnt is not cleared by valid octets within CS_CHECK.
    step(0, 1, DWORD, 4'h0, 4'h5, 4'h0, 2'd1, 8'd0, "inv_accum");
    step(0, 1, DWORD, 4'h0, 4'h1, 4'h0, 2'd0, 8'd1, "inv_limit");
    step(0, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd2, 8'd1, "relock");
    // Three disparity errors drop to CS_INIT; octet 3 /K/ starts k_cnt at 1.
    step(0, 1, 32'hBC11_2233, 4'h8, 4'h0, 4'h7, 2'd0, 8'd2, "t4_loss");
    step(0, 1, 32'h00BC_BCBC, 4'h7, 4'h0, 4'h0, 2'd2, 8'd2, "t4_relock");
    // Resync wins over an erroneous word; loss not incremented.
    step(1, 1, DWORD, 4'h0, 4'hF, 4'hF, 2'd0, 8'd2, "t5_rst_prio");
    // /K/ with disparity error is not a /K/.
    step(0, 1, KWORD, 4'hF, 4'h0, 4'h1, 2'd0, 8'd2, "k_with_err");
    step(0, 1, 32'h0000_00BC, 4'h1, 4'h0, 4'h0, 2'd2, 8'd2, "k_with_err_lock");
    // K flag on a non-0xBC octet is not a /K/.
    step(1, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd0, 8'd2, "rst2");
    step(0, 1, 32'hBCBC_BC7C, 4'hF, 4'h0, 4'h0, 2'd0, 8'd2, "k_bad_code");
    step(0, 1, 32'h0000_00BC, 4'h1, 4'h0, 4'h0, 2'd2, 8'd2, "k_bad_code_lock");
    // valid_i=0 holds k_cnt in CS_INIT.
    step(1, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd0, 8'd2, "rst3");
    step(0, 1, 32'hBCBC_0000, 4'hC, 4'h0, 4'h0, 2'd0, 8'd2, "k_two");
    step(0, 0, 32'h0000_0000, 4'h0, 4'h0, 4'h0, 2'd0, 8'd2, "k_hold");
    step(0, 1, 32'h0000_BCBC, 4'h3, 4'h0, 4'h0, 2'd2, 8'd2, "k_hold_lock");
    // Asynchronous reset between edges while in CS_CHECK.
    step(0, 1, DWORD, 4'h0, 4'h1, 4'h0, 2'd1, 8'd2, "t6_check");
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_async_state", {6'd0, st}, 8'd0);
    chk("t6_async_det", {7'd0, det}, 8'd0);
    chk("t6_async_loss", loss, 8'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, KWORD, 4'hF, 4'h0, 4'h0, 2'd0, 8'd0, "t6_idle");
    end
    step(0, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd2, 8'd0, "t6_resume");
    // Loss counter saturates at 0xFF.
    l = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (l != 8'hFF) l = l + 8'd1;
      step(0, 1, 32'h0, 4'h0, 4'h0, 4'hF, 2'd0, l, "sat_loss");
      step(0, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd2, l, "sat_relock");
    end
    step(1, 1, KWORD, 4'hF, 4'h0, 4'h0, 2'd0, 8'hFF, "sat_rst_keeps");
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
